// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared constants, FSM state type and bank-select decode
// for the 32x8 burst-loaded memory (ram_loader_32x8 and ram_bank_8x8).
package ram_loader_pkg;

    localparam int unsigned ADDR_W = 5;   // 32 locations
    localparam int unsigned DATA_W = 8;   // byte wide
    localparam int unsigned BANKS  = 4;   // four 8x8 banks
    localparam int unsigned ROW_W  = 3;   // row address inside one bank
    localparam int unsigned CNT_W  = 6;   // burst length 0..32

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // 2-to-4 one-hot decode of the bank field (address bits [4:3])
    function automatic logic [BANKS-1:0] dec2to4(input logic [1:0] sel);
        logic [BANKS-1:0] onehot;
        onehot = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/ram_bank_8x8.sv
// ram_bank_8x8: one 8x8 storage bank of the 32x8 memory.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low clear of all eight bytes
//   cs     in   bank select (one-hot across the four banks)
//   we     in   write enable, qualified by cs
//   addr   in   3-bit write row
//   din    in   8-bit write data
//   raddr  in   3-bit read row (independent read port)
//   dout   out  8-bit combinational read data
module ram_bank_8x8
    import ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              we,
    input  logic [ROW_W-1:0]  addr,
    input  logic [DATA_W-1:0] din,
    input  logic [ROW_W-1:0]  raddr,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] r_mem [8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_mem[i] <= '0;
            end
        end else if (cs && we) begin
            r_mem[addr] <= din;
        end
    end

    assign dout = r_mem[raddr];

endmodule

// File: rtl/ram_loader_32x8.sv
// ram_loader_32x8: writable 32x8 memory filled by a sequential burst loader.
// A start in IDLE captures base_addr/count; each accepted valid/ready beat
// writes wr_data to the current address, which then advances modulo 32.
// Storage is four 8x8 banks selected by address bits [4:3].
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin burst (sampled only in IDLE)
//   base_addr[4:0]  first write address
//   count[5:0]      beats in burst, 0..32
//   wr_data[7:0]    write byte; wr_valid/wr_ready handshake
//   busy            high in LOAD and DONE
//   done            one-cycle pulse when the burst completes
//   addrb[4:0], read_en, datab[7:0]  combinational read port (0 when disabled)
//   csum[7:0]       running byte checksum, present only with CHECKSUM_EN defined
module ram_loader_32x8
    import ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    input  logic [ADDR_W-1:0] addrb,
    input  logic              read_en,
`ifdef CHECKSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    output logic [DATA_W-1:0] datab
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic              w_start_acc;
    logic              w_beat;
    logic [BANKS-1:0]  w_bank_sel;
    logic [DATA_W-1:0] w_bank_dout [BANKS];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and Moore/handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        wr_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        w_start_acc = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                if (wr_valid) begin
                    w_beat = 1'b1;
                    if (r_remaining == CNT_W'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Burst address / beat counter; the 5-bit add wraps 31 -> 0 naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_addr   <= '0;
            r_remaining <= '0;
        end else if (w_start_acc) begin
            r_wr_addr   <= base_addr;
            r_remaining <= count;
        end else if (w_beat) begin
            r_wr_addr   <= r_wr_addr + ADDR_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum <= '0;
        end else if (w_start_acc) begin
            r_csum <= '0;
        end else if (w_beat) begin
            r_csum <= r_csum + wr_data;
        end
    end

    assign csum = r_csum;
`endif

    assign w_bank_sel = dec2to4(r_wr_addr[ADDR_W-1:ROW_W]);

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ram_bank_8x8 u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .cs    (w_bank_sel[b]),
            .we    (w_beat),
            .addr  (r_wr_addr[ROW_W-1:0]),
            .din   (wr_data),
            .raddr (addrb[ROW_W-1:0]),
            .dout  (w_bank_dout[b])
        );
    end

    assign datab = read_en ? w_bank_dout[addrb[ADDR_W-1:ROW_W]] : '0;

endmodule

// File: tb/tb_ram_loader_32x8.sv
module tb_ram_loader_32x8;
    import ram_loader_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addrb;
    logic              read_en;
    logic [DATA_W-1:0] datab;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    ram_loader_32x8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done),
        .addrb     (addrb),
        .read_en   (read_en),
`ifdef CHECKSUM_EN
        .csum      (csum),
`endif
        .datab     (datab)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total;
    int unsigned n_bad;
    int unsigned done_seen;
    logic [7:0]  model [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  burst_data [32];

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard read: expectation pushed from the model, popped against datab
    task automatic sb_read(input logic [4:0] a, input logic en, input string tag);
        addrb   = a;
        read_en = en;
        exp_q.push_back(en ? model[a] : 8'h00);
        #1;
        check_eq(tag, {24'h0, datab}, {24'h0, exp_q.pop_front()});
    endtask

    task automatic read_all(input logic en, input string tag);
        for (int unsigned a = 0; a < 32; a++) begin
            sb_read(5'(a), en, tag);
        end
        read_en = 1'b0;
        @(posedge clk); #1;
    endtask

    // Called at posedge+1. stall_at >= cnt means no stall.
    task automatic run_burst(input logic [4:0] base, input int unsigned cnt,
                             input int unsigned stall_at, input int unsigned stall_len);
        int unsigned d0;
        logic [4:0]  a;
        logic [7:0]  sum;
        d0  = done_seen;
        a   = base;
        sum = 8'h00;
        start     = 1'b1;
        base_addr = base;
        count     = 6'(cnt);
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = ~base;   // must not be re-sampled
        count     = 6'd7;
        if (cnt == 0) begin
            check_eq("cnt0_done", {31'h0, done}, 32'd1);
            check_eq("cnt0_busy", {31'h0, busy}, 32'd1);
            @(posedge clk); #1;
            check_eq("cnt0_done_low", {31'h0, done}, 32'd0);
            check_eq("cnt0_busy_low", {31'h0, busy}, 32'd0);
        end else begin
            check_eq("load_ready", {31'h0, wr_ready}, 32'd1);
            for (int unsigned i = 0; i < cnt; i++) begin
                if (i == stall_at) begin
                    wr_valid = 1'b0;
                    repeat (stall_len) begin
                        start     = 1'b1;   // ignored outside IDLE
                        base_addr = 5'd3;
                        @(posedge clk); #1;
                        start = 1'b0;
                        check_eq("stall_ready", {31'h0, wr_ready}, 32'd1);
                        check_eq("stall_done", {31'h0, done}, 32'd0);
                    end
                end
                wr_valid = 1'b1;
                wr_data  = burst_data[i];
                sb_read(a, 1'b1, "pre_write");
                @(posedge clk); #1;
                model[a] = burst_data[i];
                sum      = sum + burst_data[i];
                sb_read(a, 1'b1, "post_write");
                a = a + 5'd1;
            end
            wr_valid = 1'b0;
            read_en  = 1'b0;
            check_eq("done_pulse", {31'h0, done}, 32'd1);
            check_eq("done_busy", {31'h0, busy}, 32'd1);
            check_eq("done_ready", {31'h0, wr_ready}, 32'd0);
`ifdef CHECKSUM_EN
            check_eq("csum_done", {24'h0, csum}, {24'h0, sum});
`endif
            @(posedge clk); #1;
            check_eq("idle_done", {31'h0, done}, 32'd0);
            check_eq("idle_busy", {31'h0, busy}, 32'd0);
`ifdef CHECKSUM_EN
            check_eq("csum_hold", {24'h0, csum}, {24'h0, sum});
`endif
        end
        check_eq("done_once", done_seen - d0, 32'd1);
    endtask

    initial begin
        int unsigned d0;
        n_total = 0; n_bad = 0; done_seen = 0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        wr_data = '0; wr_valid = 1'b0; addrb = '0; read_en = 1'b0;
        for (int unsigned i = 0; i < 32; i++) model[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", {31'h0, wr_ready}, 32'd0);
        check_eq("rst_busy", {31'h0, busy}, 32'd0);
        check_eq("rst_done", {31'h0, done}, 32'd0);
`ifdef CHECKSUM_EN
        check_eq("rst_csum", {24'h0, csum}, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        read_all(1'b1, "rst_mem");
        read_all(1'b0, "rd_dis");

        // Bank 0 fill
        burst_data[0] = 8'd21;  burst_data[1] = 8'd255; burst_data[2] = 8'd33;
        burst_data[3] = 8'd99;  burst_data[4] = 8'd127; burst_data[5] = 8'd13;
        burst_data[6] = 8'd10;  burst_data[7] = 8'd88;
        run_burst(5'd0, 8, 99, 0);
        read_all(1'b1, "bank0_mem");
        read_all(1'b0, "bank0_rd_dis");

        // Wrap 31 -> 0
        burst_data[0] = 8'd1; burst_data[1] = 8'd2; burst_data[2] = 8'd3; burst_data[3] = 8'd4;
        run_burst(5'd30, 4, 99, 0);
        read_all(1'b1, "wrap_mem");

        // Stall of 5 cycles between beats 1 and 2, start pulsed during LOAD
        burst_data[0] = 8'hA5; burst_data[1] = 8'h5A; burst_data[2] = 8'hC3;
        run_burst(5'd12, 3, 1, 5);
        read_all(1'b1, "stall_mem");

        // Zero-length burst
        run_burst(5'd17, 0, 99, 0);
        read_all(1'b1, "cnt0_mem");

        // Checksum wraps: 200+100+1 = 301 -> 45
        burst_data[0] = 8'd200; burst_data[1] = 8'd100; burst_data[2] = 8'd1;
        run_burst(5'd20, 3, 99, 0);
`ifdef CHECKSUM_EN
        check_eq("csum_45", {24'h0, csum}, 32'd45);
`endif
        read_all(1'b1, "csum_mem");

        // Reset midway through a 16-beat burst
        d0 = done_seen;
        start = 1'b1; base_addr = 5'd5; count = 6'd16;
        @(posedge clk); #1;
        start = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h40 + i);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 32; i++) model[i] = 8'h00;
        check_eq("abort_busy", {31'h0, busy}, 32'd0);
        check_eq("abort_ready", {31'h0, wr_ready}, 32'd0);
        check_eq("abort_done", {31'h0, done}, 32'd0);
`ifdef CHECKSUM_EN
        check_eq("abort_csum", {24'h0, csum}, 32'd0);
`endif
        @(posedge clk); #1;
        check_eq("abort_done2", {31'h0, done}, 32'd0);
        read_all(1'b1, "abort_mem");
        check_eq("abort_no_done", done_seen - d0, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
